// File: rtl/dallanma_denetleyici.sv
// Branch-resolution controller: compares resolved branch outcome with the fetch prediction,
// drives flush/redirect/stall, squashes wrong-path results and keeps saturating statistics.
module dallanma_denetleyici #(
  parameter int SAYAC_GENISLIK  = 16,
  parameter int BOSALTMA_CEVRIM = 2
) (
  input  logic                      clk_g,
  input  logic                      rst_g,
  input  logic                      dallanma_gecerli_g,
  input  logic                      kosulsuz_g,
  input  logic                      dallanma_sonuc_g,
  input  logic [31:0]               hedef_ps_g,
  input  logic [31:0]               buyruk_ps_g,
  input  logic                      tahmin_atla_g,
  input  logic [31:0]               tahmin_ps_g,
  input  logic                      getir_hazir_g,
  output logic                      yonlendir_gecerli_c,
  output logic [31:0]               yonlendir_ps_c,
  output logic                      bosalt_c,
  output logic                      durdur_c,
  output logic                      hizasiz_c,
  output logic                      guncelle_gecerli_c,
  output logic [31:0]               guncelle_ps_c,
  output logic                      guncelle_atla_c,
  output logic [SAYAC_GENISLIK-1:0] dallanma_sayaci_c,
  output logic [SAYAC_GENISLIK-1:0] yanlis_tahmin_sayaci_c
);

  typedef enum logic [1:0] {BOSTA, YONLENDIR, SUSTUR} durum_t;

  localparam int SW = (BOSALTMA_CEVRIM < 2) ? 1 : $clog2(BOSALTMA_CEVRIM + 1);
  localparam logic [SW-1:0] SUSTUR_YUK = SW'(BOSALTMA_CEVRIM);

  function automatic logic [SAYAC_GENISLIK-1:0] doyur_artir(
    input logic [SAYAC_GENISLIK-1:0] x,
    input logic                      en
  );
    if (en && !(&x)) return x + SAYAC_GENISLIK'(1);
    return x;
  endfunction

  durum_t                    r_durum;
  logic [SW-1:0]             r_sustur;
  logic                      r_yon_gecerli;
  logic [31:0]               r_yon_ps;
  logic                      r_bosalt;
  logic                      r_durdur;
  logic                      r_hizasiz;
  logic                      r_gunc_gecerli;
  logic [31:0]               r_gunc_ps;
  logic                      r_gunc_atla;
  logic [SAYAC_GENISLIK-1:0] r_dsay;
  logic [SAYAC_GENISLIK-1:0] r_ysay;

  durum_t                    w_durum_sonraki;
  logic [SW-1:0]             w_sustur_sonraki;
  logic                      w_kabul;
  logic                      w_gercek_atla;
  logic [31:0]               w_ardisik_ps;
  logic [31:0]               w_gercek_ps;
  logic [31:0]               w_tahmin_sonraki;
  logic                      w_yanlis;
  logic                      w_hizasiz;
  logic                      w_yonlendir;
  logic                      w_el_sikisma;

  logic                      w_yon_gecerli_s;
  logic [31:0]               w_yon_ps_s;
  logic                      w_bosalt_s;
  logic                      w_durdur_s;
  logic                      w_hizasiz_s;
  logic                      w_gunc_gecerli_s;
  logic [31:0]               w_gunc_ps_s;
  logic                      w_gunc_atla_s;
  logic [SAYAC_GENISLIK-1:0] w_dsay_s;
  logic [SAYAC_GENISLIK-1:0] w_ysay_s;

  assign w_kabul          = dallanma_gecerli_g && (r_durum == BOSTA);
  assign w_gercek_atla    = kosulsuz_g | dallanma_sonuc_g;
  assign w_ardisik_ps     = buyruk_ps_g + 32'd4;
  assign w_gercek_ps      = w_gercek_atla ? hedef_ps_g : w_ardisik_ps;
  assign w_tahmin_sonraki = tahmin_atla_g ? tahmin_ps_g : w_ardisik_ps;
  assign w_yanlis         = (w_gercek_ps != w_tahmin_sonraki);
  // A taken branch to a misaligned target traps instead of redirecting.
  assign w_hizasiz        = w_gercek_atla && (hedef_ps_g[1:0] != 2'b00);
  assign w_yonlendir      = w_kabul && !w_hizasiz && w_yanlis;
  assign w_el_sikisma     = (r_durum == YONLENDIR) && r_yon_gecerli && getir_hazir_g;

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      r_durum  <= BOSTA;
      r_sustur <= '0;
    end else begin
      r_durum  <= w_durum_sonraki;
      r_sustur <= w_sustur_sonraki;
    end
  end

  always_comb begin
    w_durum_sonraki  = r_durum;
    w_sustur_sonraki = r_sustur;
    case (r_durum)
      BOSTA: begin
        if (w_yonlendir) w_durum_sonraki = YONLENDIR;
      end
      YONLENDIR: begin
        if (w_el_sikisma) begin
          if (BOSALTMA_CEVRIM == 0) begin
            w_durum_sonraki = BOSTA;
          end else begin
            w_durum_sonraki  = SUSTUR;
            w_sustur_sonraki = SUSTUR_YUK;
          end
        end
      end
      SUSTUR: begin
        w_sustur_sonraki = r_sustur - SW'(1);
        if (r_sustur <= SW'(1)) w_durum_sonraki = BOSTA;
      end
      default: w_durum_sonraki = BOSTA;
    endcase
  end

  // Redirect stays asserted (and execute stalled) until fetch takes it.
  always_comb begin
    w_yon_gecerli_s  = w_yonlendir || ((r_durum == YONLENDIR) && !w_el_sikisma);
    w_yon_ps_s       = w_yonlendir ? w_gercek_ps : r_yon_ps;
    w_bosalt_s       = w_yonlendir;
    w_durdur_s       = w_yon_gecerli_s;
    w_hizasiz_s      = w_kabul && w_hizasiz;
    w_gunc_gecerli_s = w_kabul;
    w_gunc_ps_s      = w_kabul ? buyruk_ps_g : r_gunc_ps;
    w_gunc_atla_s    = w_kabul ? w_gercek_atla : r_gunc_atla;
    w_dsay_s         = doyur_artir(r_dsay, w_kabul);
    w_ysay_s         = doyur_artir(r_ysay, w_yonlendir);
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      r_yon_gecerli  <= 1'b0;
      r_yon_ps       <= '0;
      r_bosalt       <= 1'b0;
      r_durdur       <= 1'b0;
      r_hizasiz      <= 1'b0;
      r_gunc_gecerli <= 1'b0;
      r_gunc_ps      <= '0;
      r_gunc_atla    <= 1'b0;
      r_dsay         <= '0;
      r_ysay         <= '0;
    end else begin
      r_yon_gecerli  <= w_yon_gecerli_s;
      r_yon_ps       <= w_yon_ps_s;
      r_bosalt       <= w_bosalt_s;
      r_durdur       <= w_durdur_s;
      r_hizasiz      <= w_hizasiz_s;
      r_gunc_gecerli <= w_gunc_gecerli_s;
      r_gunc_ps      <= w_gunc_ps_s;
      r_gunc_atla    <= w_gunc_atla_s;
      r_dsay         <= w_dsay_s;
      r_ysay         <= w_ysay_s;
    end
  end

  assign yonlendir_gecerli_c    = r_yon_gecerli;
  assign yonlendir_ps_c         = r_yon_ps;
  assign bosalt_c               = r_bosalt;
  assign durdur_c               = r_durdur;
  assign hizasiz_c              = r_hizasiz;
  assign guncelle_gecerli_c     = r_gunc_gecerli;
  assign guncelle_ps_c          = r_gunc_ps;
  assign guncelle_atla_c        = r_gunc_atla;
  assign dallanma_sayaci_c      = r_dsay;
  assign yanlis_tahmin_sayaci_c = r_ysay;

endmodule

// File: tb/tb_dallanma_denetleyici.sv
// Scoreboard bench for dallanma_denetleyici: directed branch vectors push expected
// update/redirect records; a negedge monitor pops and compares them.
module tb_dallanma_denetleyici;
  localparam int SG = 4;
  localparam int BC = 2;

  logic clk_g = 1'b0;
  logic rst_g = 1'b1;
  logic dallanma_gecerli_g = 1'b0, kosulsuz_g = 1'b0, dallanma_sonuc_g = 1'b0;
  logic [31:0] hedef_ps_g = '0, buyruk_ps_g = '0, tahmin_ps_g = '0;
  logic tahmin_atla_g = 1'b0, getir_hazir_g = 1'b0;
  logic yonlendir_gecerli_c, bosalt_c, durdur_c, hizasiz_c, guncelle_gecerli_c, guncelle_atla_c;
  logic [31:0] yonlendir_ps_c, guncelle_ps_c;
  logic [SG-1:0] dallanma_sayaci_c, yanlis_tahmin_sayaci_c;

  always #5 clk_g = ~clk_g;

  dallanma_denetleyici #(.SAYAC_GENISLIK(SG), .BOSALTMA_CEVRIM(BC)) dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .dallanma_gecerli_g(dallanma_gecerli_g), .kosulsuz_g(kosulsuz_g),
    .dallanma_sonuc_g(dallanma_sonuc_g), .hedef_ps_g(hedef_ps_g),
    .buyruk_ps_g(buyruk_ps_g), .tahmin_atla_g(tahmin_atla_g),
    .tahmin_ps_g(tahmin_ps_g), .getir_hazir_g(getir_hazir_g),
    .yonlendir_gecerli_c(yonlendir_gecerli_c), .yonlendir_ps_c(yonlendir_ps_c),
    .bosalt_c(bosalt_c), .durdur_c(durdur_c), .hizasiz_c(hizasiz_c),
    .guncelle_gecerli_c(guncelle_gecerli_c), .guncelle_ps_c(guncelle_ps_c),
    .guncelle_atla_c(guncelle_atla_c), .dallanma_sayaci_c(dallanma_sayaci_c),
    .yanlis_tahmin_sayaci_c(yanlis_tahmin_sayaci_c)
  );

  typedef struct {
    logic [31:0]   ps;
    logic          atla;
    logic          hiz;
    logic          bos;
    logic [SG-1:0] d;
    logic [SG-1:0] y;
  } gunc_t;
  typedef struct {
    logic [31:0] ps;
    int          tutma;
  } yon_t;

  gunc_t gq[$];
  yon_t  yq[$];
  int n_chk = 0;
  int n_err = 0;
  logic [SG-1:0] b_d = '0, b_y = '0;

  function automatic logic [SG-1:0] sat(input logic [SG-1:0] x);
    return (&x) ? x : x + SG'(1);
  endfunction

  task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    n_chk++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", ad, gercek, beklenen);
    end
  endtask

  // One input cycle; expectations are hand-computed by the caller.
  task automatic surec(input logic gec, input logic kos, input logic son,
                       input logic [31:0] hedef, input logic [31:0] buyruk,
                       input logic tatla, input logic [31:0] tps, input logic hazir,
                       input logic kabul, input logic hiz, input logic yanlis,
                       input logic [31:0] yps, input int tutma);
    gunc_t g;
    yon_t  r;
    @(posedge clk_g); #1;
    dallanma_gecerli_g = gec; kosulsuz_g = kos; dallanma_sonuc_g = son;
    hedef_ps_g = hedef; buyruk_ps_g = buyruk; tahmin_atla_g = tatla;
    tahmin_ps_g = tps; getir_hazir_g = hazir;
    if (kabul) begin
      b_d = sat(b_d);
      if (yanlis) b_y = sat(b_y);
      g.ps = buyruk; g.atla = kos | son; g.hiz = hiz; g.bos = yanlis; g.d = b_d; g.y = b_y;
      gq.push_back(g);
      if (yanlis) begin
        r.ps = yps; r.tutma = tutma;
        yq.push_back(r);
      end
    end
  endtask

  task automatic bos(input int n, input logic hazir);
    for (int i = 0; i < n; i++) surec(0, 0, 0, 0, 0, 0, 0, hazir, 0, 0, 0, 0, 0);
  endtask

  task automatic cikislar_sifir(input string ek);
    chk({"rst_yg_", ek}, yonlendir_gecerli_c, 0);
    chk({"rst_yps_", ek}, yonlendir_ps_c, 0);
    chk({"rst_bos_", ek}, bosalt_c, 0);
    chk({"rst_dur_", ek}, durdur_c, 0);
    chk({"rst_hiz_", ek}, hizasiz_c, 0);
    chk({"rst_gg_", ek}, guncelle_gecerli_c, 0);
    chk({"rst_gps_", ek}, guncelle_ps_c, 0);
    chk({"rst_ga_", ek}, guncelle_atla_c, 0);
    chk({"rst_ds_", ek}, 32'(dallanma_sayaci_c), 0);
    chk({"rst_ys_", ek}, 32'(yanlis_tahmin_sayaci_c), 0);
  endtask

  logic          m_onceki_gec = 1'b0;
  logic          m_hs_onceki = 1'b0;
  logic [31:0]   m_onceki_ps = '0;
  int            m_tutma = 0;
  logic [SG-1:0] m_d = '0, m_y = '0;

  always @(negedge clk_g) begin
    gunc_t e;
    yon_t  r;
    if (rst_g) begin
      m_onceki_gec = 1'b0; m_hs_onceki = 1'b0; m_tutma = 0; m_d = '0; m_y = '0;
    end else begin
      chk("durdur_eq_gecerli", durdur_c, yonlendir_gecerli_c);
      if (guncelle_gecerli_c) begin
        if (gq.size() == 0) begin
          chk("beklenmeyen_guncelle", guncelle_ps_c, 32'hFFFF_FFFF);
        end else begin
          e = gq.pop_front();
          chk("guncelle_ps", guncelle_ps_c, e.ps);
          chk("guncelle_atla", guncelle_atla_c, e.atla);
          chk("hizasiz", hizasiz_c, e.hiz);
          chk("bosalt", bosalt_c, e.bos);
          chk("dallanma_sayaci", 32'(dallanma_sayaci_c), 32'(e.d));
          chk("yanlis_sayaci", 32'(yanlis_tahmin_sayaci_c), 32'(e.y));
          m_d = e.d; m_y = e.y;
        end
      end else begin
        chk("hizasiz_bosta", hizasiz_c, 0);
        chk("bosalt_bosta", bosalt_c, 0);
        chk("dsay_sabit", 32'(dallanma_sayaci_c), 32'(m_d));
        chk("ysay_sabit", 32'(yanlis_tahmin_sayaci_c), 32'(m_y));
      end
      if (m_hs_onceki) chk("yon_dusus", yonlendir_gecerli_c, 0);
      m_hs_onceki = 1'b0;
      if (yonlendir_gecerli_c) begin
        if (m_onceki_gec) chk("yon_sabit", yonlendir_ps_c, m_onceki_ps);
        m_tutma++;
        if (getir_hazir_g) begin
          if (yq.size() == 0) begin
            chk("beklenmeyen_yon", yonlendir_ps_c, 32'hFFFF_FFFF);
          end else begin
            r = yq.pop_front();
            chk("yon_ps", yonlendir_ps_c, r.ps);
            chk("yon_tutma", 32'(m_tutma), 32'(r.tutma));
          end
          m_tutma = 0;
          m_hs_onceki = 1'b1;
        end
      end
      m_onceki_gec = yonlendir_gecerli_c & ~getir_hazir_g;
      m_onceki_ps  = yonlendir_ps_c;
    end
  end

  initial begin
    repeat (3) @(posedge clk_g);
    #1 cikislar_sifir("bas");
    @(negedge clk_g); #2 rst_g = 1'b0;

    // Correct taken prediction
    surec(1, 0, 1, 32'h140, 32'h100, 1, 32'h140, 0, 1, 0, 0, 0, 0);
    // Not-taken mispredict, fetch busy 3 cycles; then squash window
    surec(1, 0, 0, 32'h280, 32'h200, 1, 32'h300, 0, 1, 0, 1, 32'h204, 4);
    bos(3, 0);
    bos(1, 1);
    surec(1, 0, 1, 32'h900, 32'h880, 0, 0, 0, 0, 0, 0, 0, 0);
    surec(1, 0, 1, 32'h900, 32'h884, 0, 0, 0, 0, 0, 0, 0, 0);
    surec(1, 0, 0, 32'h504, 32'h500, 0, 0, 0, 1, 0, 0, 0, 0);
    // JAL to misaligned target traps
    surec(1, 1, 0, 32'h402, 32'h600, 0, 0, 0, 1, 1, 0, 0, 0);
    // Not-taken with misaligned target field is no trap; same-cycle handshake
    surec(1, 0, 0, 32'h403, 32'h610, 1, 32'h700, 0, 1, 0, 1, 32'h614, 1);
    bos(1, 1); bos(2, 0);
    // Fall-through wraps to 0
    surec(1, 0, 0, 32'h20, 32'hFFFF_FFFC, 1, 32'h10, 0, 1, 0, 1, 32'h0, 1);
    bos(1, 1); bos(2, 0);
    // Taken but predicted not taken
    surec(1, 0, 1, 32'h800, 32'h700, 0, 0, 0, 1, 0, 1, 32'h800, 2);
    bos(1, 0); bos(1, 1); bos(2, 0);
    // JAL with wrong predicted target
    surec(1, 1, 0, 32'h900, 32'h880, 1, 32'h940, 0, 1, 0, 1, 32'h900, 1);
    bos(1, 1); bos(2, 0);
    // Back-to-back correct predictions drive branch counter into saturation
    for (int i = 0; i < 10; i++)
      surec(1, 0, 0, 0, 32'h1000 + 32'(4 * i), 0, 0, 0, 1, 0, 0, 0, 0);
    // Repeated mispredicts saturate the misprediction counter
    for (int i = 0; i < 12; i++) begin
      surec(1, 0, 0, 0, 32'h2000 + 32'(16 * i), 1, 32'h3000, 0, 1, 0, 1,
            32'h2004 + 32'(16 * i), 1);
      bos(1, 1); bos(2, 0);
    end
    // Asynchronous reset while redirect pending
    surec(1, 0, 0, 0, 32'h4000, 1, 32'h4100, 0, 1, 0, 1, 32'h4004, 99);
    bos(2, 0);
    @(posedge clk_g); #3 rst_g = 1'b1;
    #1 cikislar_sifir("orta");
    gq.delete(); yq.delete(); b_d = '0; b_y = '0;
    repeat (2) @(negedge clk_g);
    #2 rst_g = 1'b0;
    surec(1, 0, 1, 32'h5040, 32'h5000, 1, 32'h5040, 0, 1, 0, 0, 0, 0);
    bos(4, 0);
    @(posedge clk_g); #1;
    chk("gq_bos", 32'(gq.size()), 0);
    chk("yq_bos", 32'(yq.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dallanma_denetleyici.md
Name: dallanma_denetleyici

Overview:
- Branch-resolution controller behind the execute-stage branch unit.
- Each cycle it may receive one resolved branch or jump: taken flag, computed target, instruction PC, plus the fetch-stage prediction carried down the pipe.
- On a misprediction it issues a single-cycle flush, holds a redirect PC with a valid/ready handshake to fetch, stalls execute until fetch accepts, then squashes wrong-path branch results for a fixed window.
- Also emits predictor-update pulses and saturating statistics counters.

Parameters:
- SAYAC_GENISLIK, 16, width of statistics counters.
- BOSALTMA_CEVRIM, 2, cycles after redirect acceptance during which incoming branch results are ignored (0 allowed).

Ports:
- clk_g  input  1  clock, all state on rising edge.
- rst_g  input  1  asynchronous, active-high reset.
- dallanma_gecerli_g  input  1  resolved branch/jump present this cycle.
- kosulsuz_g  input  1  1 = JAL/JALR (always taken).
- dallanma_sonuc_g  input  1  branch-unit taken result (ignored when kosulsuz_g=1).
- hedef_ps_g  input  32  branch-unit target PC.
- buyruk_ps_g  input  32  PC of the resolving instruction.
- tahmin_atla_g  input  1  fetch predicted taken.
- tahmin_ps_g  input  32  fetch predicted target.
- getir_hazir_g  input  1  fetch accepts redirect.
- yonlendir_gecerli_c  output  1  redirect valid.
- yonlendir_ps_c  output  32  redirect PC.
- bosalt_c  output  1  one-cycle pipeline flush pulse.
- durdur_c  output  1  stall execute.
- hizasiz_c  output  1  one-cycle misaligned-target pulse.
- guncelle_gecerli_c  output  1  predictor update pulse.
- guncelle_ps_c  output  32  update PC.
- guncelle_atla_c  output  1  update taken outcome.
- dallanma_sayaci_c  output  SAYAC_GENISLIK  accepted branches.
- yanlis_tahmin_sayaci_c  output  SAYAC_GENISLIK  mispredictions.

Behaviour:
- All outputs are registered. On reset every output is 0, state is BOSTA, and the squash counter is 0.
- Reset mid-operation drops any pending redirect immediately, with no flush pulse.
- An input is accepted when dallanma_gecerli_g=1 and state is BOSTA. In YONLENDIR and SUSTUR, dallanma_gecerli_g is ignored entirely: no counters, no update, no pulses.
- Resolution for an accepted input:
  - gercek_atla = kosulsuz_g | dallanma_sonuc_g.
  - gercek_ps = gercek_atla ? hedef_ps_g : buyruk_ps_g+4.
  - tahmin_sonraki = tahmin_atla_g ? tahmin_ps_g : buyruk_ps_g+4.
  - Additions are 32-bit and wrap mod 2^32.
  - yanlis = (gercek_ps != tahmin_sonraki).
- Misaligned target: if gercek_atla=1 and hedef_ps_g[1:0]!=0, the input is treated as a trap:
  - hizasiz_c=1 for one cycle.
  - No redirect, no flush, no misprediction count.
  - Branch count and predictor update still happen.
  - State stays BOSTA.
- Accepted input at cycle T, effects visible at T+1:
  - guncelle_gecerli_c=1 for one cycle, with guncelle_ps_c=buyruk_ps_g and guncelle_atla_c=gercek_atla.
  - dallanma_sayaci_c+1, saturating at all ones.
- Accepted, aligned, yanlis=1, additionally at T+1:
  - bosalt_c=1 for exactly one cycle.
  - yonlendir_gecerli_c=1 and yonlendir_ps_c=gercek_ps.
  - durdur_c=1.
  - yanlis_tahmin_sayaci_c+1, saturating.
  - State goes to YONLENDIR.
- Correct prediction: no redirect, state stays BOSTA, back-to-back acceptance every cycle.
- State YONLENDIR:
  - yonlendir_gecerli_c and yonlendir_ps_c are held stable until the handshake (valid & getir_hazir_g sampled high).
  - The cycle after the handshake: valid=0, durdur_c=0.
  - Next state is SUSTUR with counter=BOSALTMA_CEVRIM, or BOSTA if BOSALTMA_CEVRIM=0.
  - getir_hazir_g high in the same cycle valid first rises completes the handshake that cycle.
- State SUSTUR: the counter decrements each cycle. In the cycle the counter reaches 1, the next state is BOSTA, so SUSTUR lasts exactly BOSALTMA_CEVRIM cycles.
- getir_hazir_g outside YONLENDIR has no effect.

Test Plan:
- Correct-taken prediction: BEQ taken, buyruk_ps=0x100, hedef=0x140, tahmin_atla=1, tahmin_ps=0x140 -> no bosalt/redirect; update pulse ps=0x100 atla=1; dallanma_sayaci=1, yanlis=0.
- Not-taken mispredict: BNE not taken, ps=0x200, tahmin_atla=1, tahmin_ps=0x300, getir_hazir=0 for 3 cycles -> T+1 bosalt pulse; redirect 0x204 held with durdur=1 for 4 cycles until ready; yanlis=1.
- Squash window: after handshake with BOSALTMA_CEVRIM=2, assert dallanma_gecerli every cycle -> the 2 cycles after acceptance are ignored (counters unchanged), the third is accepted.
- JAL misaligned: kosulsuz=1, hedef=0x402 -> hizasiz pulse, no redirect, dallanma_sayaci+1, yanlis unchanged.
- Wrap and saturation: ps=0xFFFFFFFC not taken, predicted taken to 0x10 -> redirect 0x00000000; preload counters to all ones (SAYAC_GENISLIK=4, 16 branches) -> stays 0xF.
- Reset in YONLENDIR: assert rst_g asynchronously while redirect pending -> all outputs 0 immediately, next branch accepted in BOSTA.
